// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, bus layouts
// and load-op codes.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 140;
  localparam int MS_TO_WS_BUS_WD = 135;
  localparam int MS_FORWARD_WD   = 40;
  localparam int CSR_WD          = 47;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b101,
    LD_HU = 3'b110
  } ld_op_e;

  // EX->MS bus, MSB first (csr lands at [139:93], pc at [31:0]).
  typedef struct packed {
    logic [CSR_WD-1:0] csr;
    logic              req_sent;
    logic              ertn;
    logic [15:0]       excp_num;
    logic              excp;
    logic [2:0]        ld_op;
    logic              res_from_mem;
    logic              gr_we;
    logic [4:0]        dest;
    logic [31:0]       alu_result;
    logic [31:0]       pc;
  } es_to_ms_bus_t;

  // MS->WS bus, MSB first (csr lands at [134:88], pc at [31:0]).
  typedef struct packed {
    logic [CSR_WD-1:0] csr;
    logic              ertn;
    logic [15:0]       excp_num;
    logic              excp;
    logic              gr_we;
    logic [4:0]        dest;
    logic [31:0]       final_result;
    logic [31:0]       pc;
  } ms_to_ws_bus_t;

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a load word and extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  off,
  input  logic [31:0] ld_data,
  output logic [31:0] result
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_data[{off, 3'b000} +: 8];
  assign ld_half = ld_data[{off[1], 4'b0000} +: 16];

  // Extension per load op; unknown codes yield zero.
  always_comb begin
    result = 32'h0;
    case (ld_op)
      LD_W:    result = ld_data;
      LD_B:    result = {{24{ld_byte[7]}}, ld_byte};
      LD_H:    result = {{16{ld_half[15]}}, ld_half};
      LD_BU:   result = {24'h0, ld_byte};
      LD_HU:   result = {16'h0, ld_half};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: collects data-SRAM responses, aligns load data, buffers one
// response under WB backpressure and drops responses of flushed requests.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       excp_flush,
  input  logic                       ertn_flush,
  output logic [MS_FORWARD_WD-1:0]   ms_forward,
  output logic                       ms_excp_ertn
);

  logic          ms_valid_q;
  es_to_ms_bus_t ms_bus_q;
  es_to_ms_bus_t es_bus;
  logic          buf_valid_q;
  logic [31:0]   buf_rdata_q;
  logic [1:0]    drop_cnt_q;
  logic [1:0]    drop_cnt_d;
  logic [2:0]    drop_sum;

  logic          flush;
  logic          resp_ok;
  logic          wait_resp;
  logic          ms_ready_go;
  logic          ms_load;
  logic          buf_capture;
  logic          drop_dec;
  logic          es_in_req;
  logic [31:0]   ld_data;
  logic [31:0]   ld_result;
  logic [31:0]   final_result;
  ms_to_ws_bus_t ws_bus;

  assign es_bus      = es_bus_t_cast(es_to_ms_bus);
  assign flush       = excp_flush | ertn_flush;
  assign resp_ok     = data_sram_data_ok & (drop_cnt_q == 2'd0);
  assign wait_resp   = ms_valid_q & ms_bus_q.req_sent & ~buf_valid_q;
  assign ms_ready_go = ~wait_resp | resp_ok;
  assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_load     = es_to_ms_valid & ms_allowin;
  assign buf_capture = wait_resp & resp_ok & ~ws_allowin & ~flush;
  assign drop_dec    = (drop_cnt_q != 2'd0) & data_sram_data_ok;
  assign es_in_req   = ms_load & es_bus.req_sent;

  function automatic es_to_ms_bus_t es_bus_t_cast(input logic [ES_TO_MS_BUS_WD-1:0] b);
    return es_to_ms_bus_t'(b);
  endfunction

  // Drop count: a flush orphans the waiting MS request and any request
  // entering this cycle; a response already pending for an older dropped
  // request still retires one count.
  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} - {2'b00, drop_dec};
    drop_cnt_d = drop_sum[1:0];
    if (flush) begin
      drop_sum   = drop_sum + {2'b00, wait_resp & ~resp_ok} + {2'b00, es_in_req};
      drop_cnt_d = (drop_sum > 3'd2) ? 2'd2 : drop_sum[1:0];
    end
  end

  // Control state: valid, response buffer flag and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      drop_cnt_q  <= 2'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      if (flush) begin
        ms_valid_q <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid_q <= es_to_ms_valid;
      end
      if (ms_load) begin
        buf_valid_q <= 1'b0;
      end else if (buf_capture) begin
        buf_valid_q <= 1'b1;
      end
    end
  end

  // Payload registers; qualified by the valid flags so no reset needed.
  always_ff @(posedge clk) begin
    if (ms_load) begin
      ms_bus_q <= es_bus;
    end
    if (buf_capture) begin
      buf_rdata_q <= data_sram_rdata;
    end
  end

  assign ld_data = buf_valid_q ? buf_rdata_q : data_sram_rdata;

  mem_load_align u_load_align (
    .ld_op   (ms_bus_q.ld_op),
    .off     (ms_bus_q.alu_result[1:0]),
    .ld_data (ld_data),
    .result  (ld_result)
  );

  assign final_result = ms_bus_q.res_from_mem ? ld_result : ms_bus_q.alu_result;

  assign ws_bus.csr          = ms_bus_q.csr;
  assign ws_bus.ertn         = ms_bus_q.ertn;
  assign ws_bus.excp_num     = ms_bus_q.excp_num;
  assign ws_bus.excp         = ms_bus_q.excp;
  assign ws_bus.gr_we        = ms_bus_q.gr_we;
  assign ws_bus.dest         = ms_bus_q.dest;
  assign ws_bus.final_result = final_result;
  assign ws_bus.pc           = ms_bus_q.pc;

  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign ms_to_ws_bus   = ws_bus;
  assign ms_excp_ertn   = ms_valid_q & (ms_bus_q.excp | ms_bus_q.ertn);
  assign ms_forward     = {ms_valid_q & ms_bus_q.res_from_mem & ~ms_ready_go,
                           final_result, ms_bus_q.dest, ms_bus_q.gr_we, ms_valid_q};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-cycle results plus
// hand sequences for late responses, backpressure, flush drops and reset.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [139:0] es_to_ms_bus;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [134:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         excp_flush;
  logic         ertn_flush;
  logic [39:0]  ms_forward;
  logic         ms_excp_ertn;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .excp_flush        (excp_flush),
    .ertn_flush        (ertn_flush),
    .ms_forward        (ms_forward),
    .ms_excp_ertn      (ms_excp_ertn)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [2:0]  ld_op;
    logic        rfm;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [139:0] mk_bus(input logic [31:0] pc, input logic [31:0] alu,
                                          input logic [4:0] dest, input logic rfm,
                                          input logic [2:0] ld_op, input logic req,
                                          input logic excp, input logic [15:0] excp_num,
                                          input logic ertn, input logic [46:0] csr);
    return {csr, req, ertn, excp_num, excp, ld_op, rfm, 1'b1, dest, alu, pc};
  endfunction

  function automatic logic [139:0] ld_bus(input logic [31:0] pc, input logic [2:0] ld_op,
                                          input logic [31:0] addr);
    return mk_bus(pc, addr, 5'd9, 1'b1, ld_op, 1'b1, 1'b0, 16'h0, 1'b0, 47'h0);
  endfunction

  initial begin
    vecs[0]  = '{name:"ldb_off3",   ld_op:3'b001, rfm:1'b1, alu:32'h1000_0003, rdata:32'h80FF_1234, exp:32'hFFFF_FF80};
    vecs[1]  = '{name:"ldbu_off3",  ld_op:3'b101, rfm:1'b1, alu:32'h1000_0003, rdata:32'h80FF_1234, exp:32'h0000_0080};
    vecs[2]  = '{name:"ldb_off0",   ld_op:3'b001, rfm:1'b1, alu:32'h1000_0000, rdata:32'h80FF_1234, exp:32'h0000_0034};
    vecs[3]  = '{name:"ldb_off1",   ld_op:3'b001, rfm:1'b1, alu:32'h1000_0001, rdata:32'h80FF_1234, exp:32'h0000_0012};
    vecs[4]  = '{name:"ldb_off2",   ld_op:3'b001, rfm:1'b1, alu:32'h1000_0002, rdata:32'h80FF_1234, exp:32'hFFFF_FFFF};
    vecs[5]  = '{name:"ldh_off0",   ld_op:3'b010, rfm:1'b1, alu:32'h1000_0000, rdata:32'h80FF_1234, exp:32'h0000_1234};
    vecs[6]  = '{name:"ldh_off2",   ld_op:3'b010, rfm:1'b1, alu:32'h1000_0002, rdata:32'h80FF_1234, exp:32'hFFFF_80FF};
    vecs[7]  = '{name:"ldhu_off2",  ld_op:3'b110, rfm:1'b1, alu:32'h1000_0002, rdata:32'h80FF_1234, exp:32'h0000_80FF};
    vecs[8]  = '{name:"ldw",        ld_op:3'b000, rfm:1'b1, alu:32'h1000_0000, rdata:32'h80FF_1234, exp:32'h80FF_1234};
    vecs[9]  = '{name:"ld_badop",   ld_op:3'b011, rfm:1'b1, alu:32'h1000_0000, rdata:32'h80FF_1234, exp:32'h0000_0000};
    vecs[10] = '{name:"alu_5",      ld_op:3'b000, rfm:1'b0, alu:32'h0000_0005, rdata:32'h80FF_1234, exp:32'h0000_0005};
    vecs[11] = '{name:"alu_beef",   ld_op:3'b001, rfm:1'b0, alu:32'hDEAD_BEEF, rdata:32'h1111_1111, exp:32'hDEAD_BEEF};

    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    excp_flush = 1'b0;
    ertn_flush = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_to_ws_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("rst_allowin", 64'(ms_allowin), 64'd1);
    chk("rst_excp_ertn", 64'(ms_excp_ertn), 64'd0);
    chk("rst_fwd_valid", 64'(ms_forward[0]), 64'd0);
    tick();
    reset = 1'b0;

    // Table: every instruction answered in its MS-entry cycle.
    for (int i = 0; i < 12; i++) begin
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_bus(32'h1C00_0000 + 32'(i) * 4, vecs[i].alu, 5'(i + 1), vecs[i].rfm,
                            vecs[i].ld_op, vecs[i].rfm, 1'b0, 16'h0, 1'b0, 47'h0);
      tick();
      es_to_ms_valid = 1'b0;
      data_sram_data_ok = vecs[i].rfm;
      data_sram_rdata = vecs[i].rdata;
      @(negedge clk);
      chk({vecs[i].name, "_valid"}, 64'(ms_to_ws_valid), 64'd1);
      chk({vecs[i].name, "_result"}, 64'(ms_to_ws_bus[63:32]), 64'(vecs[i].exp));
      chk({vecs[i].name, "_fwd_res"}, 64'(ms_forward[38:7]), 64'(vecs[i].exp));
      chk({vecs[i].name, "_dest"}, 64'(ms_to_ws_bus[68:64]), 64'(i + 1));
      chk({vecs[i].name, "_pending"}, 64'(ms_forward[39]), 64'd0);
      tick();
      data_sram_data_ok = 1'b0;
    end

    // ld.hu whose response arrives three cycles late.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = ld_bus(32'h1C00_1000, 3'b110, 32'h2000_0002);
    tick();
    es_to_ms_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_pending", 64'(ms_forward[39]), 64'd1);
      chk("late_allowin", 64'(ms_allowin), 64'd0);
      chk("late_valid", 64'(ms_to_ws_valid), 64'd0);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h9ABC_1234;
    @(negedge clk);
    chk("late_done_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("late_done_result", 64'(ms_to_ws_bus[63:32]), 64'h0000_9ABC);
    chk("late_done_pending", 64'(ms_forward[39]), 64'd0);
    tick();
    data_sram_data_ok = 1'b0;

    // ld.w answered under WB backpressure, then rdata turns to garbage.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = ld_bus(32'h1C00_2000, 3'b000, 32'h2000_0000);
    tick();
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1122_3344;
    @(negedge clk);
    chk("bp_c0_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("bp_c0_allowin", 64'(ms_allowin), 64'd0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("bp_c1_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("bp_c1_result", 64'(ms_to_ws_bus[63:32]), 64'h1122_3344);
    chk("bp_c1_allowin", 64'(ms_allowin), 64'd0);
    tick();
    ws_allowin = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("bp_rel_result", 64'(ms_to_ws_bus[63:32]), 64'h1122_3344);
    chk("bp_rel_allowin", 64'(ms_allowin), 64'd1);
    tick();

    // Two orphaned requests: waiting load flushed, then a load entering
    // during a second flush. The next load must take the third response.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = ld_bus(32'h1C00_3000, 3'b000, 32'h2000_0010);
    tick();
    es_to_ms_valid = 1'b0;
    excp_flush = 1'b1;
    tick();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = ld_bus(32'h1C00_3004, 3'b000, 32'h2000_0014);
    @(negedge clk);
    chk("drop_flush2_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("drop_flush2_allowin", 64'(ms_allowin), 64'd1);
    tick();
    excp_flush = 1'b0;
    es_to_ms_bus = ld_bus(32'h1C00_3008, 3'b000, 32'h2000_0018);
    tick();
    es_to_ms_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'hBAD0_0000 + 32'(k);
      @(negedge clk);
      chk("drop_ignored_valid", 64'(ms_to_ws_valid), 64'd0);
      chk("drop_ignored_pending", 64'(ms_forward[39]), 64'd1);
      tick();
    end
    data_sram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("drop_third_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("drop_third_result", 64'(ms_to_ws_bus[63:32]), 64'hCAFE_F00D);
    tick();
    data_sram_data_ok = 1'b0;

    // Flush coincident with the MS load's own response: nothing dropped.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = ld_bus(32'h1C00_4000, 3'b000, 32'h2000_0020);
    tick();
    es_to_ms_valid = 1'b0;
    ertn_flush = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0BAD_0BAD;
    tick();
    ertn_flush = 1'b0;
    data_sram_data_ok = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = ld_bus(32'h1C00_4004, 3'b000, 32'h2000_0024);
    @(negedge clk);
    chk("coinc_flushed_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("coinc_allowin", 64'(ms_allowin), 64'd1);
    tick();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h5566_7788;
    @(negedge clk);
    chk("coinc_next_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("coinc_next_result", 64'(ms_to_ws_bus[63:32]), 64'h5566_7788);
    tick();
    data_sram_data_ok = 1'b0;

    // Exception-carrying ALU op passes through with fields intact.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(32'h1C00_5000, 32'h0000_0005, 5'd3, 1'b0, 3'b000, 1'b0,
                          1'b1, 16'h0020, 1'b0, 47'h5A5A_1234_5678);
    tick();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("excp_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("excp_result", 64'(ms_to_ws_bus[63:32]), 64'h5);
    chk("excp_pc", 64'(ms_to_ws_bus[31:0]), 64'h1C00_5000);
    chk("excp_bit", 64'(ms_to_ws_bus[70]), 64'd1);
    chk("excp_num", 64'(ms_to_ws_bus[86:71]), 64'h0020);
    chk("excp_ertn_bit", 64'(ms_to_ws_bus[87]), 64'd0);
    chk("excp_csr", 64'(ms_to_ws_bus[134:88]), 64'h5A5A_1234_5678);
    chk("excp_flag", 64'(ms_excp_ertn), 64'd1);
    chk("excp_fwd_dest", 64'(ms_forward[6:2]), 64'd3);
    chk("excp_fwd_valid", 64'(ms_forward[0]), 64'd1);
    tick();
    @(negedge clk);
    chk("excp_flag_clear", 64'(ms_excp_ertn), 64'd0);

    // ertn also raises the flag.
    tick();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(32'h1C00_5004, 32'h0, 5'd0, 1'b0, 3'b000, 1'b0,
                          1'b0, 16'h0, 1'b1, 47'h0);
    tick();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("ertn_flag", 64'(ms_excp_ertn), 64'd1);
    chk("ertn_bit", 64'(ms_to_ws_bus[87]), 64'd1);
    tick();

    // Reset while a load waits, then a fresh load completes normally.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = ld_bus(32'h1C00_6000, 3'b000, 32'h2000_0030);
    tick();
    es_to_ms_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("rst_mid_allowin", 64'(ms_allowin), 64'd1);
    tick();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = ld_bus(32'h1C00_6004, 3'b000, 32'h2000_0034);
    tick();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h7654_3210;
    @(negedge clk);
    chk("rst_after_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("rst_after_result", 64'(ms_to_ws_bus[63:32]), 64'h7654_3210);
    tick();
    data_sram_data_ok = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth stage of the five-stage LoongArch pipeline, between the EX stage and wb_stage.
- Collects the data-SRAM response for loads and stores issued by EX.
- Aligns and sign/zero-extends load data, then forms the final result.
- Passes exception/ertn/CSR fields unchanged to WB and provides forwarding/stall info to ID.
- Holds a one-entry response buffer so data_ok is never lost under WB backpressure.
- Discards stale responses that belong to flushed instructions.

Parameters:
- ES_TO_MS_BUS_WD, 140, EX→MS bus width (`ES_TO_MS_BUS_WD in myCPU.h).
- MS_TO_WS_BUS_WD, 135, MS→WS bus width (`MS_TO_WS_BUS_WD).
- MS_FORWARD_WD, 40, forward bus width (`MS_FORWARD_WD).

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- ms_allowin  out  1  MS can accept an instruction this cycle.
- es_to_ms_valid  in  1  EX presents a valid instruction.
- es_to_ms_bus  in  140  [31:0] pc, [63:32] alu_result, [68:64] dest, [69] gr_we, [70] res_from_mem, [73:71] ld_op, [74] excp, [90:75] excp_num, [91] ertn, [92] req_sent, [139:93] csr {we, num[13:0], wdata[31:0]}.
- ws_allowin  in  1  WB can accept.
- ms_to_ws_valid  out  1  valid instruction to WB.
- ms_to_ws_bus  out  135  [31:0] pc, [63:32] final_result, [68:64] dest, [69] gr_we, [70] excp, [86:71] excp_num, [87] ertn, [134:88] csr fields.
- data_sram_data_ok  in  1  one in-order response per accepted request, reads and writes alike.
- data_sram_rdata  in  32  read data, valid when data_ok=1.
- excp_flush  in  1  exception commit in WB.
- ertn_flush  in  1  ertn commit in WB.
- ms_forward  out  40  [0] valid, [1] gr_we, [6:2] dest, [38:7] final_result, [39] load data pending.
- ms_excp_ertn  out  1  ms_valid & (excp | ertn); EX suppresses new stores while this is high.

Behaviour:
- Reset values:
  - ms_valid=0, buf_valid=0, drop_cnt=0.
  - Therefore ms_to_ws_valid=0, ms_allowin=1, ms_excp_ertn=0, ms_forward[0]=0.
  - Bus registers may hold any value; consumers qualify them by valid.
- flush = excp_flush | ertn_flush.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- Valid register:
  - If flush: ms_valid<=0.
  - Else if ms_allowin: ms_valid<=es_to_ms_valid.
- The bus register loads on es_to_ms_valid & ms_allowin; on load, buf_valid<=0.
- resp_ok = data_sram_data_ok & (drop_cnt==0).
- wait_resp = ms_valid & req_sent & !buf_valid.
- ms_ready_go = !wait_resp | resp_ok.
- Response buffering: if wait_resp & resp_ok & !ws_allowin, then buf_rdata<=rdata and buf_valid<=1. Later data_ok pulses do not overwrite the buffer.
- Load data:
  - ld_data = buf_valid ? buf_rdata : data_sram_rdata.
  - off = alu_result[1:0].
  - Byte = ld_data[8*off +: 8]; halfword = ld_data[16*off[1] +: 16].
  - ld_op encoding: 000 w, 001 b (sext), 010 h (sext), 101 bu (zext), 110 hu (zext). Other codes produce 0.
- final_result = res_from_mem ? extended load data : alu_result.
- ms_to_ws_valid = ms_valid & ms_ready_go. Latency is 1 cycle when data_ok arrives in the MS-entry cycle or is already buffered.
- Exception or ertn instructions pass through unchanged. If excp=1, req_sent is 0 by construction in EX.
- Flush and response drop:
  - In a flush cycle: drop_cnt += (wait_resp & !data_sram_data_ok) + (es_to_ms_valid & ms_allowin & es_to_ms_bus[92]).
  - drop_cnt is 2 bits; its maximum is 2.
  - While drop_cnt>0, each data_ok decrements it and is ignored.
  - If data_ok coincides with flush while drop_cnt==0, that response belongs to the MS instruction and is consumed; nothing is added to drop_cnt for it.
  - An instruction entering while drop_cnt>0 waits until the count drains.
- Forwarding: ms_forward[39] = ms_valid & res_from_mem & !ms_ready_go. ID stalls on a matching dest while this bit is set.
- Reset mid-transaction clears all state. The memory interface is reset in the same cycle, so no drop is needed.

Decomposition:
- Shared header myCPU.h holds:
  - bus widths ES_TO_MS_BUS_WD, MS_TO_WS_BUS_WD, MS_FORWARD_WD;
  - bus field offsets;
  - LD_W/LD_B/LD_H/LD_BU/LD_HU codes.
- One natural sub-module: mem_load_align (combinational; inputs ld_op, off, ld_data; output 32-bit result).
- Response buffer and drop counter stay in mem_stage.

Test Plan:
- ld.b at addr 0x...3, rdata=0x80FF_1234, data_ok in entry cycle, ws_allowin=1 → ms_to_ws_valid next-cycle-free, final_result=0xFFFF_FF80; ld.bu → 0x0000_0080.
- ld.hu at off=2, rdata=0x9ABC_1234, data_ok arrives 3 cycles late → ms_forward[39]=1 for 3 cycles, ms_allowin=0, then final_result=0x0000_9ABC.
- ld.w with data_ok while ws_allowin=0 for 2 cycles, data_sram_rdata changes to garbage afterwards → buffered 0x1122_3344 delivered when ws_allowin rises.
- Load waiting in MS plus a second load with req_sent entering in the flush cycle → drop_cnt=2; next two data_ok ignored; a subsequent ld.w completes with the third response.
- flush coincident with data_ok for the MS load → drop_cnt stays 0, ms_valid=0 next cycle, the following response goes to the next load.
- Non-memory add, alu_result=0x5, excp=1, excp_num=0x0020 → passes in 1 cycle with fields intact; ms_excp_ertn=1 while valid.
